// File: rtl/rv32i_types.sv
// Shared rv32i type definitions: arbiter state and transaction-owner encodings.
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_ISSUE = 3'd1,
    I_WAIT  = 3'd2,
    D_ISSUE = 3'd3,
    D_WAIT  = 3'd4
  } mem_arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } mem_arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data requesters; one latched
// transaction at a time, one-cycle mask pulse, response steered to the owner.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter bit D_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  mem_arb_state_t r_state, w_next_state;
  mem_arb_owner_t r_last, w_cur_owner, w_prev_owner;
  logic [31:0]    r_addr, r_wdata;
  logic [3:0]     r_rmask, r_wmask;

  logic w_ireq, w_dreq, w_in_xfer, w_issue, w_done, w_sample;
  logic w_grant_i, w_grant_d;

  always_comb begin
    w_ireq       = |imem_rmask;
    w_dreq       = (|dmem_rmask) || (|dmem_wmask);
    w_in_xfer    = (r_state != IDLE);
    w_issue      = (r_state == I_ISSUE) || (r_state == D_ISSUE);
    w_cur_owner  = ((r_state == D_ISSUE) || (r_state == D_WAIT)) ? ARB_D : ARB_I;
    w_done       = w_in_xfer && mem_resp;
    w_sample     = (r_state == IDLE) || w_done;
    // The owner of the transaction finishing this cycle decides the
    // anti-starvation rule; from IDLE the last completed owner is used.
    w_prev_owner = w_done ? w_cur_owner : r_last;
    w_grant_i    = w_ireq && (!w_dreq || (w_prev_owner == ARB_D) || !D_FIRST);
    w_grant_d    = w_dreq && !w_grant_i;

    w_next_state = r_state;
    case (r_state)
      I_ISSUE: if (!mem_resp) w_next_state = I_WAIT;
      D_ISSUE: if (!mem_resp) w_next_state = D_WAIT;
      default: w_next_state = r_state;
    endcase
    if (w_sample) begin
      if (w_grant_i)      w_next_state = I_ISSUE;
      else if (w_grant_d) w_next_state = D_ISSUE;
      else                w_next_state = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= ARB_I;
      r_addr  <= '0;
      r_rmask <= '0;
      r_wmask <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_done) r_last <= w_cur_owner;
      if (w_sample && w_grant_i) begin
        r_addr  <= imem_addr;
        r_rmask <= imem_rmask;
        r_wmask <= '0;
        r_wdata <= '0;
      end else if (w_sample && w_grant_d) begin
        r_addr  <= dmem_addr;
        r_rmask <= dmem_rmask;
        r_wmask <= dmem_wmask;
        r_wdata <= dmem_wdata;
      end
    end
  end

  // Memory side comes only from the latches; masks pulse in ISSUE only.
  always_comb begin
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    mem_rmask = w_issue ? r_rmask : 4'h0;
    mem_wmask = w_issue ? r_wmask : 4'h0;
  end

  always_comb begin
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
    imem_resp  = w_done && (w_cur_owner == ARB_I);
    dmem_resp  = w_done && (w_cur_owner == ARB_D);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.D_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    logic [3:0]  im;
    logic [31:0] ia;
    logic [3:0]  drm;
    logic [3:0]  dwm;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        mr;
    logic [31:0] mrd;
    logic [31:0] e_addr;
    logic [3:0]  e_rm;
    logic [3:0]  e_wm;
    logic [31:0] e_wd;
    logic        e_ir;
    logic        e_dr;
  } vec_t;

  int    vectors = 0;
  int    miscompares = 0;
  string cur;
  vec_t  tbl[$];

  function automatic vec_t mk(logic [3:0] im, logic [31:0] ia, logic [3:0] drm,
                              logic [3:0] dwm, logic [31:0] da, logic [31:0] dwd,
                              logic mr, logic [31:0] mrd, logic [31:0] ea,
                              logic [3:0] erm, logic [3:0] ewm, logic [31:0] ewd,
                              logic eir, logic edr);
    vec_t v;
    v.im = im; v.ia = ia; v.drm = drm; v.dwm = dwm; v.da = da; v.dwd = dwd;
    v.mr = mr; v.mrd = mrd; v.e_addr = ea; v.e_rm = erm; v.e_wm = ewm;
    v.e_wd = ewd; v.e_ir = eir; v.e_dr = edr;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got 0x%08h, expected 0x%08h", cur, nm, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    imem_rmask = v.im;  imem_addr = v.ia;
    dmem_rmask = v.drm; dmem_wmask = v.dwm; dmem_addr = v.da; dmem_wdata = v.dwd;
    mem_resp   = v.mr;  mem_rdata = v.mrd;
    #2;
    vectors++;
    cur = tag;
    cmp("mem_addr",   mem_addr,   v.e_addr);
    cmp("mem_rmask",  {28'd0, mem_rmask}, {28'd0, v.e_rm});
    cmp("mem_wmask",  {28'd0, mem_wmask}, {28'd0, v.e_wm});
    cmp("mem_wdata",  mem_wdata,  v.e_wd);
    cmp("imem_resp",  {31'd0, imem_resp}, {31'd0, v.e_ir});
    cmp("dmem_resp",  {31'd0, dmem_resp}, {31'd0, v.e_dr});
    cmp("imem_rdata", imem_rdata, v.mrd);
    cmp("dmem_rdata", dmem_rdata, v.mrd);
  endtask

  initial begin
    rst = 1'b1;
    imem_rmask = 4'h0; imem_addr = '0;
    dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_addr = '0; dmem_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fetch only, then simultaneous store + fetch with data priority.
    tbl.push_back(mk(4'hF, 32'h60000000, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                     32'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                     32'h60000000, 4'hF, 4'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                     32'h60000000, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h12345678,
                     32'h60000000, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                     32'h60000000, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk(4'hF, 32'h60000004, 4'h0, 4'h3, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0,
                     32'h60000000, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk(4'hF, 32'h60000004, 4'h0, 4'h3, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0,
                     32'h1000, 4'h0, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0));
    tbl.push_back(mk(4'hF, 32'h60000004, 4'h0, 4'h3, 32'h1000, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D,
                     32'h1000, 4'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1));
    tbl.push_back(mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D,
                     32'h60000004, 4'hF, 4'h0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                     32'h60000004, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Continuous load + fetch: grants must alternate D, I, D, I.
    apply("alt_idle", mk(4'hF, 32'h60000010, 4'hF, 4'h0, 32'h2000, 32'hA5A5A5A5, 1'b0, 32'h0,
                         32'h60000004, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      apply($sformatf("alt%0d_issue", k),
            mk(4'hF, 32'h60000010, 4'hF, 4'h0, 32'h2000, 32'hA5A5A5A5, 1'b0, 32'h0,
               (k % 2 == 0) ? 32'h2000 : 32'h60000010, 4'hF, 4'h0,
               (k % 2 == 0) ? 32'hA5A5A5A5 : 32'h0, 1'b0, 1'b0));
      apply($sformatf("alt%0d_wait", k),
            mk(4'hF, 32'h60000010, 4'hF, 4'h0, 32'h2000, 32'hA5A5A5A5, 1'b1, 32'h100 + k,
               (k % 2 == 0) ? 32'h2000 : 32'h60000010, 4'h0, 4'h0,
               (k % 2 == 0) ? 32'hA5A5A5A5 : 32'h0, (k % 2 == 1), (k % 2 == 0)));
    end
    apply("alt_last", mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h55,
                         32'h2000, 4'hF, 4'h0, 32'hA5A5A5A5, 1'b0, 1'b1));

    // Zero-wait memory, fetch only: one completion per cycle.
    apply("zw_idle", mk(4'hF, 32'h60000020, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                        32'h2000, 4'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 1'b0));
    for (int j = 0; j < 4; j++)
      apply($sformatf("zw%0d", j),
            mk((j < 3) ? 4'hF : 4'h0, 32'h60000020 + 32'(4 * (j + 1)), 4'h0, 4'h0,
               32'h0, 32'h0, 1'b1, 32'(j), 32'h60000020 + 32'(4 * j), 4'hF, 4'h0,
               32'h0, 1'b1, 1'b0));

    // Address changes while the fetch is in flight.
    apply("ac0", mk(4'hF, 32'h60000008, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    32'h6000002C, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    apply("ac1", mk(4'hF, 32'h60000100, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    32'h60000008, 4'hF, 4'h0, 32'h0, 1'b0, 1'b0));
    apply("ac2", mk(4'hF, 32'h60000100, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    32'h60000008, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    apply("ac3", mk(4'hF, 32'h60000100, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h77,
                    32'h60000008, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0));
    apply("ac4", mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h88,
                    32'h60000100, 4'hF, 4'h0, 32'h0, 1'b1, 1'b0));

    // Reset while a load waits in D_WAIT; the late response must be dropped.
    apply("rs0", mk(4'h0, 32'h0, 4'hF, 4'h0, 32'h3000, 32'h11112222, 1'b0, 32'h0,
                    32'h60000100, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    apply("rs1", mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    32'h3000, 4'hF, 4'h0, 32'h11112222, 1'b0, 1'b0));
    apply("rs2", mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    32'h3000, 4'h0, 4'h0, 32'h11112222, 1'b0, 1'b0));
    #1 rst = 1'b1;
    #1;
    vectors++;
    cur = "rs_async";
    cmp("mem_addr",  mem_addr, 32'h0);
    cmp("mem_rmask", {28'd0, mem_rmask}, 32'h0);
    cmp("mem_wmask", {28'd0, mem_wmask}, 32'h0);
    cmp("mem_wdata", mem_wdata, 32'h0);
    cmp("resp", {30'd0, imem_resp, dmem_resp}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    apply("rs3", mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    32'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    apply("rs4", mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h99,
                    32'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
    apply("rs5", mk(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    32'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port between the fetch stage (instruction requester) and the memory stage (data requester) of the rv32i pipeline. Latches one request at a time and drives it onto the memory port with a one-cycle mask pulse. Holds address and write data until `mem_resp`, then steers the response back to the owning requester. Data accesses win by default; an anti-starvation rule keeps fetch from stalling indefinitely.

## Interface
- `D_FIRST`, 1: with 1, data has priority on simultaneous requests; with 0, instruction has priority.
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_addr` in 32: fetch address.
- `imem_rmask` in 4: fetch read mask; nonzero means a request.
- `imem_rdata` out 32: equals `mem_rdata`, unconditionally.
- `imem_resp` out 1: fetch response, one cycle.
- `dmem_addr` in 32: data address.
- `dmem_rmask` in 4 / `dmem_wmask` in 4: data masks; either nonzero means a request.
- `dmem_wdata` in 32: store data.
- `dmem_rdata` out 32: equals `mem_rdata`, unconditionally.
- `dmem_resp` out 1: data response, one cycle.
- `mem_addr` out 32, `mem_rmask` out 4, `mem_wmask` out 4, `mem_wdata` out 32: memory request.
- `mem_rdata` in 32, `mem_resp` in 1: memory response.

## Operation
- States: IDLE, I_ISSUE, I_WAIT, D_ISSUE, D_WAIT.
- Request sampling:
  - Sampled at the edge while in IDLE, or at the `mem_resp` edge while in any WAIT or ISSUE state.
  - On grant, the address, masks and wdata of the granted requester are latched into internal registers.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: the `D_FIRST` winner is granted.
  - Exception: if the transaction just completed was a data access and `imem_rmask` is nonzero, the instruction request wins.
- In x_ISSUE:
  - `mem_rmask`/`mem_wmask` are driven from the latched masks.
  - Next state is x_WAIT, unless `mem_resp` is high in this cycle.
- In x_WAIT:
  - Masks are 0.
  - `mem_addr` and `mem_wdata` keep their latched values.
- Response handling:
  - `mem_resp` in x_ISSUE or x_WAIT drives the owner's `*_resp` high combinationally in the same cycle.
  - The other requester's resp stays 0.
  - Next state is the ISSUE state of a new grant if a request is pending, else IDLE (back-to-back, no idle bubble).
- `mem_resp` in IDLE is dropped; no `*_resp` is generated.
- Instruction requests always latch `mem_wmask`=0 and `mem_wdata`=0.
- A data request with both masks nonzero is illegal. It is forwarded unchanged, with no checking.
- Once latched, a transaction runs to completion; requester inputs are ignored until `mem_resp`. If a requester changes its address or drops its mask mid-transaction, the original transaction still completes and its resp is still delivered.
- The latched values are the only source of the `mem_*` outputs; `mem_*` outputs never combinationally follow `imem_*`/`dmem_*`.

## Timing
- Reset (asynchronous): state=IDLE, last-owner=instruction.
- Reset values of `mem_*` outputs: `mem_addr`=0, `mem_rmask`=0, `mem_wmask`=0, `mem_wdata`=0.
- Reset values of response outputs: `imem_resp`=0, `dmem_resp`=0.
- Reset mid-transaction: the request is abandoned, and a late `mem_resp` arrives in IDLE and is dropped.
- Latency:
  - Request present at edge N → masks on `mem_*` during cycle N+1.
  - Zero-wait memory (`mem_resp` in cycle N+1) → `*_resp` in cycle N+1.
  - Total: 1 cycle plus memory wait states.
- The mask pulse lasts exactly one cycle per transaction.
- Back-to-back: `mem_resp` at edge M with a pending request → the next mask pulse is in cycle M+1.

## Structure
- rv32i_types gets `mem_arb_state_t`: an enum for the five states, encoded as 3 bits.
- rv32i_types gets `mem_arb_owner_t`: 1 bit, with values `ARB_I` and `ARB_D`.
- Single module; no sub-module is warranted.
- Recommended internal split: one always_ff for state and latches, one always_comb for next-state/grant, one always_comb for resp steering.

## Test plan
- Reset, then fetch only, `imem_addr`=0x60000000, memory replies after 2 wait cycles:
  - `mem_rmask`=1111 for exactly one cycle, then 0.
  - `mem_addr` holds 0x60000000.
  - `imem_resp` is high in the `mem_resp` cycle; `dmem_resp` stays 0.
- Simultaneous requests, `D_FIRST`=1, imem 0x60000004, dmem store 0x1000 with `wmask`=0011 and `wdata`=0xDEADBEEF:
  - The store issues first with `mem_wmask`=0011 and `mem_wdata`=0xDEADBEEF.
  - The fetch issues the cycle after the store's `mem_resp`.
- Continuous data requests with continuous fetch: the grants alternate D, I, D, I; fetch is never starved.
- Zero-wait memory (`mem_resp` in every ISSUE cycle), fetch only: one completed fetch per cycle after the first, with no idle cycles.
- Fetch latched at 0x60000008, then `imem_addr` changes to 0x60000100 in WAIT:
  - `mem_addr` stays 0x60000008.
  - `imem_resp` is still delivered.
  - 0x60000100 issues next.
- `rst` asserted mid-D_WAIT, with `mem_resp` arriving two cycles after release:
  - Outputs clear immediately, including `mem_addr`=0 and masks=0.
  - The late `mem_resp` produces no `dmem_resp` and no `imem_resp`.
